// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the synchronous FIFO slice.
// Holds the default geometry/threshold constants, the per-cycle operation
// encoding used by the controller, and the occupancy-width helper.
package fifo_pkg;

  localparam int DEFAULT_NO_OF_WORDS        = 3;
  localparam int DEFAULT_BITS_PER_WORD      = 8;
  localparam int DEFAULT_ALMOST_FULL_LEVEL  = 6;
  localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 2;

  // What actually happens to the queue on a given edge, after the
  // accept rules have filtered the raw requests.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Occupancy runs 0..2**aw inclusive, so it needs one bit more than a pointer.
  function automatic int occupancy_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag bookkeeping for fifo_sync_buffer.
// Decides which requests are accepted each cycle and tells the storage in
// the top level where to write and read. Synchronous active-high reset.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int no_of_words        = DEFAULT_NO_OF_WORDS,
  parameter int almost_full_level  = DEFAULT_ALMOST_FULL_LEVEL,
  parameter int almost_empty_level = DEFAULT_ALMOST_EMPTY_LEVEL
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_i,
  input  logic                   rd_i,
  output logic                   wr_en_o,
  output logic                   rd_en_o,
  output logic [no_of_words-1:0] wr_addr_o,
  output logic [no_of_words-1:0] rd_addr_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [no_of_words:0]   count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int DEPTH = 1 << no_of_words;
  localparam int CNT_W = occupancy_width(no_of_words);

  logic [no_of_words-1:0] wr_ptr_q, wr_ptr_d;
  logic [no_of_words-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;

  logic     full, empty;
  logic     wr_accept, rd_accept;
  fifo_op_e op;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Accept rules: a full FIFO still takes a write when a read frees a slot
  // on the same edge; reset overrides both requests.
  always_comb begin
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    op        = OP_IDLE;
    if (!reset_i) begin
      wr_accept = wr_i && (!full || rd_i);
      rd_accept = rd_i && !empty;
    end
    case ({rd_accept, wr_accept})
      2'b01:   op = OP_WRITE;
      2'b10:   op = OP_READ;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // Next-state: pointers wrap naturally at the pointer width, occupancy only
  // moves on an unpaired operation, error flags are sticky.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (wr_i && full && !rd_i);
    underflow_d = underflow_q | (rd_i && empty);
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    case (op)
      OP_WRITE: count_d = count_q + 1'b1;
      OP_READ:  count_d = count_q - 1'b1;
      default:  count_d = count_q;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_en_o        = wr_accept;
  assign rd_en_o        = rd_accept;
  assign wr_addr_o      = wr_ptr_q;
  assign rd_addr_o      = rd_ptr_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= CNT_W'(almost_full_level));
  assign almost_empty_o = (count_q <= CNT_W'(almost_empty_level));
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: rtl/fifo_sync_buffer.sv
// fifo_sync_buffer: single-clock FIFO with occupancy, threshold and sticky
// error flags. Storage and the read-data path live here; bookkeeping lives
// in fifo_ctrl. Define FIFO_FWFT_EN for first-word-fall-through read data;
// otherwise r_data is a register loaded on each accepted read.
module fifo_sync_buffer
  import fifo_pkg::*;
#(
  parameter int no_of_words        = DEFAULT_NO_OF_WORDS,
  parameter int bits_per_word      = DEFAULT_BITS_PER_WORD,
  parameter int almost_full_level  = DEFAULT_ALMOST_FULL_LEVEL,
  parameter int almost_empty_level = DEFAULT_ALMOST_EMPTY_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [bits_per_word-1:0] w_data,
  output logic [bits_per_word-1:0] r_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [no_of_words:0]     count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << no_of_words;

  logic                     wr_en, rd_en;
  logic [no_of_words-1:0]   wr_addr, rd_addr;
  logic [bits_per_word-1:0] mem_q [DEPTH];

  fifo_ctrl #(
    .no_of_words       (no_of_words),
    .almost_full_level (almost_full_level),
    .almost_empty_level(almost_empty_level)
  ) u_ctrl (
    .clk_i         (clk),
    .reset_i       (reset),
    .wr_i          (wr),
    .rd_i          (rd),
    .wr_en_o       (wr_en),
    .rd_en_o       (rd_en),
    .wr_addr_o     (wr_addr),
    .rd_addr_o     (rd_addr),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full),
    .almost_empty_o(almost_empty),
    .count_o       (count),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  // Storage is deliberately not reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= w_data;
  end

`ifdef FIFO_FWFT_EN
  logic unused_rd_en;
  assign unused_rd_en = rd_en;
  assign r_data       = mem_q[rd_addr];
`else
  logic [bits_per_word-1:0] r_data_q;

  // Capture the head word as it is popped; holds between reads.
  always_ff @(posedge clk) begin
    if (reset)      r_data_q <= '0;
    else if (rd_en) r_data_q <= mem_q[rd_addr];
  end

  assign r_data = r_data_q;
`endif

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// tb_fifo_sync_buffer: directed and randomized checks of fifo_sync_buffer
// against a queue-based reference model. Honours FIFO_FWFT_EN.
module tb_fifo_sync_buffer;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int         vectors = 0;
  int         miscompares = 0;

  logic [7:0] q[$];
  logic       ovM = 1'b0;
  logic       unM = 1'b0;
  logic [7:0] rdataM = '0;

  fifo_sync_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .rd          (rd),
    .w_data      (w_data),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int n;
    n = q.size();
    checkVal("count", 32'(count), 32'(n));
    checkVal("full", 32'(full), 32'(n == DEPTH));
    checkVal("empty", 32'(empty), 32'(n == 0));
    checkVal("almost_full", 32'(almost_full), 32'(n >= AF));
    checkVal("almost_empty", 32'(almost_empty), 32'(n <= AE));
    checkVal("overflow", 32'(overflow), 32'(ovM));
    checkVal("underflow", 32'(underflow), 32'(unM));
`ifdef FIFO_FWFT_EN
    if (n > 0) checkVal("r_data_head", 32'(r_data), 32'(q[0]));
`else
    checkVal("r_data", 32'(r_data), 32'(rdataM));
`endif
  endtask

  // Drive one cycle of requests, advance the model on the edge, then check.
  task automatic applyStimulus(input logic rst, input logic w, input logic r, input logic [7:0] d);
    logic fullM, emptyM;
    reset  = rst;
    wr     = w;
    rd     = r;
    w_data = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      ovM    = 1'b0;
      unM    = 1'b0;
      rdataM = '0;
    end else begin
      fullM  = (q.size() == DEPTH);
      emptyM = (q.size() == 0);
      if (w && fullM && !r) ovM = 1'b1;
      if (r && emptyM) unM = 1'b1;
      if (r && !emptyM) rdataM = q.pop_front();
      if (w && (!fullM || r)) q.push_back(d);
    end
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
  endtask

  initial begin
    $display("[TB] start");

    // Reset with both requests asserted: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkVal("reset_count", 32'(count), 32'd0);
    checkVal("reset_empty", 32'(empty), 32'd1);

    // Fill with 11..18, then one extra write to force overflow.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
    checkVal("filled_full", 32'(full), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h99);
    checkVal("overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    checkVal("last_drained", 32'(r_data), 32'h18);
`endif

    // Refill, then a simultaneous read+write while full.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hAA);
    checkVal("full_rdwr_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
    checkVal("aa_last", 32'(r_data), 32'hAA);
`endif

    // Empty with read+write: write lands, read ignored, underflow set.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
    checkVal("empty_rdwr_underflow", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Interleaved traffic across the pointer wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 3) != 0, 8'($urandom));
      checkVal("count_le_depth", 32'(count <= 4'd8), 32'd1);
    end
    while (q.size() > 0) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Mid-stream reset discards queued words.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Read-data timing mode check.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
`ifdef FIFO_FWFT_EN
    checkVal("fwft_head_before_rd", 32'(r_data), 32'h3C);
`else
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("reg_rdata_after_rd", 32'(r_data), 32'h3C);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < 50, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
